// File: rtl/mesi_isc_breq_pkg.sv
// Shared encodings for the breq front end: main-bus commands, broadcast types and the queued entry layout.
// No logic here; the top declares a parameter-sized twin of breq_entry_t for non-default widths.
package mesi_isc_breq_pkg;

  typedef enum logic [2:0] {
    MBUS_CMD_NOP      = 3'd0,
    MBUS_CMD_WR       = 3'd1,
    MBUS_CMD_RD       = 3'd2,
    MBUS_CMD_WR_BROAD = 3'd3,
    MBUS_CMD_RD_BROAD = 3'd4
  } mbus_cmd_e;

  typedef enum logic [1:0] {
    BROAD_TYPE_NOP = 2'd0,
    BROAD_TYPE_WR  = 2'd1,
    BROAD_TYPE_RD  = 2'd2
  } broad_type_e;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_CPU_ID_WIDTH   = 2;
  localparam int DEF_BROAD_ID_WIDTH = 7;

  // Field order is the FIFO word layout, MSB first.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]     addr;
    broad_type_e                   btype;
    logic [DEF_CPU_ID_WIDTH-1:0]   cpu_id;
    logic [DEF_BROAD_ID_WIDTH-1:0] id;
  } breq_entry_t;

endpackage

// File: rtl/mesi_isc_breq_fifos_n_if.sv
// Main-bus request side and broadcast-FIFO side of the breq front end.
// master = CPU/broadcast-FIFO environment, slave = the breq block.
interface mesi_isc_breq_fifos_n_if #(
  parameter int CPU_NUM          = 4,
  parameter int MBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 7,
  parameter int BREQ_FIFO_DEPTH  = 2
);
  localparam int CPU_ID_WIDTH = $clog2(CPU_NUM);
  localparam int LVL_WIDTH    = $clog2(BREQ_FIFO_DEPTH) + 1;

  logic [CPU_NUM*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i;
  logic [CPU_NUM*ADDR_WIDTH-1:0]     mbus_addr_array_i;
  logic                              broad_fifo_status_full_i;
  logic [CPU_NUM-1:0]                mbus_ack_array_o;
  logic                              broad_fifo_wr_o;
  logic [ADDR_WIDTH-1:0]             broad_addr_o;
  logic [BROAD_TYPE_WIDTH-1:0]       broad_type_o;
  logic [CPU_ID_WIDTH-1:0]           broad_cpu_id_o;
  logic [BROAD_ID_WIDTH-1:0]         broad_id_o;
  logic [CPU_NUM*LVL_WIDTH-1:0]      fifo_level_array_o;
  logic [CPU_NUM-1:0]                fifo_full_array_o;

  modport master (
    output mbus_cmd_array_i, mbus_addr_array_i, broad_fifo_status_full_i,
    input  mbus_ack_array_o, broad_fifo_wr_o, broad_addr_o, broad_type_o,
           broad_cpu_id_o, broad_id_o, fifo_level_array_o, fifo_full_array_o
  );

  modport slave (
    input  mbus_cmd_array_i, mbus_addr_array_i, broad_fifo_status_full_i,
    output mbus_ack_array_o, broad_fifo_wr_o, broad_addr_o, broad_type_o,
           broad_cpu_id_o, broad_id_o, fifo_level_array_o, fifo_full_array_o
  );
endinterface

// File: rtl/mesi_isc_breq_port_fifo.sv
// Per-CPU request FIFO; head word is combinational from registered state, write visible next cycle.
// No internal backpressure: writes while full are dropped unless paired with a pop; the caller gates on full.
module mesi_isc_breq_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign level   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);

  // Storage is not reset: an empty FIFO's head is never observed downstream.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      cnt <= cnt + LW'(1);
      else if (do_rd && !do_wr) cnt <= cnt - LW'(1);
    end
  end
endmodule

// File: rtl/mesi_isc_breq_fifos_n.sv
// Broadcast-request front end: acks CPU broadcasts, tags them with global IDs, queues per CPU, forwards one per cycle.
// Ack one cycle after accept, forward earliest that same cycle; stalls all forwarding while the broadcast FIFO is full.
module mesi_isc_breq_fifos_n
  import mesi_isc_breq_pkg::*;
#(
  parameter int CPU_NUM          = 4,
  parameter int MBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 7,
  parameter int BREQ_FIFO_DEPTH  = 2,
  parameter int ARB_MODE         = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  mesi_isc_breq_fifos_n_if.slave   bus
);
  localparam int CPU_ID_WIDTH = $clog2(CPU_NUM);
  localparam int LVL_WIDTH    = $clog2(BREQ_FIFO_DEPTH) + 1;

  localparam logic [MBUS_CMD_WIDTH-1:0]   CMD_WR_BROAD = MBUS_CMD_WIDTH'(MBUS_CMD_WR_BROAD);
  localparam logic [MBUS_CMD_WIDTH-1:0]   CMD_RD_BROAD = MBUS_CMD_WIDTH'(MBUS_CMD_RD_BROAD);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR      = BROAD_TYPE_WIDTH'(BROAD_TYPE_WR);
  localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD      = BROAD_TYPE_WIDTH'(BROAD_TYPE_RD);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]       addr;
    logic [BROAD_TYPE_WIDTH-1:0] btype;
    logic [CPU_ID_WIDTH-1:0]     cpu_id;
    logic [BROAD_ID_WIDTH-1:0]   id;
  } entry_t;

  localparam int ENTRY_WIDTH = $bits(entry_t);

  logic [CPU_NUM-1:0]        ack_q;
  logic [CPU_NUM-1:0]        accept;
  logic [CPU_NUM-1:0]        pop;
  logic [CPU_NUM-1:0]        fifo_empty;
  logic [CPU_NUM-1:0]        fifo_full;
  logic [LVL_WIDTH-1:0]      fifo_level [CPU_NUM];
  entry_t                    wr_entry   [CPU_NUM];
  entry_t                    head       [CPU_NUM];
  entry_t                    fwd;
  logic [MBUS_CMD_WIDTH-1:0] cmd_cur;
  logic [BROAD_ID_WIDTH-1:0] id_cnt;
  logic [BROAD_ID_WIDTH-1:0] id_run;
  logic [CPU_ID_WIDTH-1:0]   rr_ptr;
  logic [CPU_ID_WIDTH-1:0]   cand;
  logic [CPU_ID_WIDTH-1:0]   grant_idx;
  logic                      grant_vld;

  // Simultaneous accepts take consecutive IDs in ascending port order.
  always_comb begin
    id_run  = id_cnt;
    accept  = '0;
    cmd_cur = '0;
    for (int i = 0; i < CPU_NUM; i++) begin
      cmd_cur            = bus.mbus_cmd_array_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
      wr_entry[i].addr   = bus.mbus_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      wr_entry[i].btype  = (cmd_cur == CMD_WR_BROAD) ? TYPE_WR : TYPE_RD;
      wr_entry[i].cpu_id = CPU_ID_WIDTH'(i);
      wr_entry[i].id     = id_run;
      accept[i]          = ((cmd_cur == CMD_WR_BROAD) || (cmd_cur == CMD_RD_BROAD)) &&
                           !fifo_full[i] && !ack_q[i];
      if (accept[i]) id_run = id_run + BROAD_ID_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < CPU_NUM; g++) begin : g_fifo
    mesi_isc_breq_port_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (BREQ_FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .wr      (accept[g]),
      .rd      (pop[g]),
      .wr_data (wr_entry[g]),
      .rd_data (head[g]),
      .level   (fifo_level[g]),
      .empty   (fifo_empty[g]),
      .full    (fifo_full[g])
    );
  end

  // First non-empty FIFO scanning from rr_ptr (round robin) or from port 0 (fixed priority).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!bus.broad_fifo_status_full_i) begin
      for (int k = 0; k < CPU_NUM; k++) begin
        if (ARB_MODE == 1) cand = CPU_ID_WIDTH'(k);
        else               cand = CPU_ID_WIDTH'((int'(rr_ptr) + k) % CPU_NUM);
        if (!grant_vld && !fifo_empty[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    fwd = '0;
    if (grant_vld) begin
      pop[grant_idx] = 1'b1;
      fwd            = head[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q  <= '0;
      id_cnt <= '0;
      rr_ptr <= '0;
    end else begin
      ack_q  <= accept;
      id_cnt <= id_run;
      if (grant_vld && (ARB_MODE == 0)) begin
        rr_ptr <= (grant_idx == CPU_ID_WIDTH'(CPU_NUM - 1)) ? '0 : grant_idx + CPU_ID_WIDTH'(1);
      end
    end
  end

  always_comb begin
    bus.fifo_level_array_o = '0;
    for (int i = 0; i < CPU_NUM; i++) begin
      bus.fifo_level_array_o[i*LVL_WIDTH +: LVL_WIDTH] = fifo_level[i];
    end
  end

  assign bus.mbus_ack_array_o  = ack_q;
  assign bus.fifo_full_array_o = fifo_full;
  assign bus.broad_fifo_wr_o   = grant_vld;
  assign bus.broad_addr_o      = fwd.addr;
  assign bus.broad_type_o      = fwd.btype;
  assign bus.broad_cpu_id_o    = fwd.cpu_id;
  assign bus.broad_id_o        = fwd.id;
endmodule

// File: tb/tb_mesi_isc_breq_fifos_n.sv
// Directed bench for the breq front end: a round-robin instance and a fixed-priority instance share clock and reset.
module tb_mesi_isc_breq_fifos_n;
  import mesi_isc_breq_pkg::*;

  localparam int N  = 4;
  localparam int CW = 3;
  localparam int AW = 32;
  localparam int TW = 2;
  localparam int IW = 7;
  localparam int D  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mesi_isc_breq_fifos_n_if #(.CPU_NUM(N), .MBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW),
    .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW), .BREQ_FIFO_DEPTH(D)) bus0 ();
  mesi_isc_breq_fifos_n_if #(.CPU_NUM(N), .MBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW),
    .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW), .BREQ_FIFO_DEPTH(D)) bus1 ();

  mesi_isc_breq_fifos_n #(.CPU_NUM(N), .MBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW),
    .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW), .BREQ_FIFO_DEPTH(D), .ARB_MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mesi_isc_breq_fifos_n #(.CPU_NUM(N), .MBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW),
    .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW), .BREQ_FIFO_DEPTH(D), .ARB_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input int cpu, input logic [CW-1:0] cmd, input logic [AW-1:0] addr);
    bus0.mbus_cmd_array_i[cpu*CW +: CW]  = cmd;
    bus0.mbus_addr_array_i[cpu*AW +: AW] = addr;
  endtask

  task automatic req1(input int cpu, input logic [CW-1:0] cmd, input logic [AW-1:0] addr);
    bus1.mbus_cmd_array_i[cpu*CW +: CW]  = cmd;
    bus1.mbus_addr_array_i[cpu*AW +: AW] = addr;
  endtask

  task automatic check_fwd0(input string tag, input logic wr, input logic [AW-1:0] addr,
                            input logic [TW-1:0] typ, input int cpu, input int id);
    check({tag, "_wr"},   bus0.broad_fifo_wr_o, wr);
    check({tag, "_addr"}, bus0.broad_addr_o,    addr);
    check({tag, "_type"}, bus0.broad_type_o,    typ);
    check({tag, "_cpu"},  bus0.broad_cpu_id_o,  64'(cpu));
    check({tag, "_id"},   bus0.broad_id_o,      64'(id));
  endtask

  task automatic check_fwd1(input string tag, input logic [AW-1:0] addr, input int cpu, input int id);
    check({tag, "_wr"},   bus1.broad_fifo_wr_o, 1'b1);
    check({tag, "_addr"}, bus1.broad_addr_o,    addr);
    check({tag, "_cpu"},  bus1.broad_cpu_id_o,  64'(cpu));
    check({tag, "_id"},   bus1.broad_id_o,      64'(id));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    bus0.mbus_cmd_array_i = '0;  bus0.mbus_addr_array_i = '0;  bus0.broad_fifo_status_full_i = 1'b0;
    bus1.mbus_cmd_array_i = '0;  bus1.mbus_addr_array_i = '0;  bus1.broad_fifo_status_full_i = 1'b0;
    #1;

    // Reset state
    check("rst_ack",  bus0.mbus_ack_array_o,   '0);
    check("rst_lvl",  bus0.fifo_level_array_o, '0);
    check("rst_full", bus0.fifo_full_array_o,  '0);
    check_fwd0("rst", 1'b0, '0, '0, 0, 0);
    tick();
    tick();
    rst = 1'b1;

    // Single request: CPU2 RD_BROAD, command held through the ack cycle
    req0(2, MBUS_CMD_RD_BROAD, 32'h1000);
    tick();
    check("t1_ack", bus0.mbus_ack_array_o, 4'b0100);
    check_fwd0("t1_fwd", 1'b1, 32'h1000, BROAD_TYPE_RD, 2, 0);
    tick();
    check("t1_ack_once", bus0.mbus_ack_array_o,   4'b0000);
    check("t1_idle_wr",  bus0.broad_fifo_wr_o,    1'b0);
    check("t1_lvl",      bus0.fifo_level_array_o, 8'h00);
    req0(2, MBUS_CMD_NOP, '0);

    // Simultaneous accepts on all four ports
    do_reset();
    for (int i = 0; i < N; i++) req0(i, MBUS_CMD_WR_BROAD, 32'hA0 + i);
    tick();
    for (int i = 0; i < N; i++) req0(i, MBUS_CMD_NOP, '0);
    check("t2_ack", bus0.mbus_ack_array_o,   4'b1111);
    check("t2_lvl", bus0.fifo_level_array_o, 8'h55);
    for (int k = 0; k < N; k++) begin
      check_fwd0("t2_fwd", 1'b1, 32'hA0 + k, BROAD_TYPE_WR, k, k);
      tick();
    end
    check("t2_drained", bus0.broad_fifo_wr_o, 1'b0);

    // Fill and block: CPU1 with the broadcast FIFO held full; IDs continue from 4
    bus0.broad_fifo_status_full_i = 1'b1;
    req0(1, MBUS_CMD_WR_BROAD, 32'h2000);
    tick();
    check("t3_ack0", bus0.mbus_ack_array_o, 4'b0010);
    req0(1, MBUS_CMD_WR_BROAD, 32'h2001);
    tick();
    check("t3_ack_gap", bus0.mbus_ack_array_o, 4'b0000);
    tick();
    check("t3_ack1",  bus0.mbus_ack_array_o,   4'b0010);
    check("t3_lvl2",  bus0.fifo_level_array_o, 8'h08);
    check("t3_full",  bus0.fifo_full_array_o,  4'b0010);
    req0(1, MBUS_CMD_WR_BROAD, 32'h2002);
    tick();
    tick();
    tick();
    check("t3_blocked_ack", bus0.mbus_ack_array_o, 4'b0000);
    check("t3_blocked_wr",  bus0.broad_fifo_wr_o,  1'b0);
    bus0.broad_fifo_status_full_i = 1'b0;
    #1;
    check_fwd0("t3_fwd0", 1'b1, 32'h2000, BROAD_TYPE_WR, 1, 4);
    tick();
    check("t3_full_pop_noack", bus0.mbus_ack_array_o,   4'b0000);
    check("t3_lvl_after_pop",  bus0.fifo_level_array_o, 8'h04);
    tick();
    check("t3_ack2",     bus0.mbus_ack_array_o,   4'b0010);
    check("t3_lvl_wrrd", bus0.fifo_level_array_o, 8'h04);
    check_fwd0("t3_fwd2", 1'b1, 32'h2002, BROAD_TYPE_WR, 1, 6);
    req0(1, MBUS_CMD_NOP, '0);
    tick();
    check("t3_empty_lvl", bus0.fifo_level_array_o, 8'h00);
    check("t3_empty_wr",  bus0.broad_fifo_wr_o,    1'b0);

    // Fixed priority: CPU0 drains completely before CPU3 is served
    bus1.broad_fifo_status_full_i = 1'b1;
    req1(0, MBUS_CMD_RD_BROAD, 32'h3000);
    req1(3, MBUS_CMD_RD_BROAD, 32'h3300);
    tick();
    req1(0, MBUS_CMD_RD_BROAD, 32'h3001);
    req1(3, MBUS_CMD_RD_BROAD, 32'h3301);
    tick();
    tick();
    req1(0, MBUS_CMD_NOP, '0);
    req1(3, MBUS_CMD_NOP, '0);
    tick();
    check("t4_lvl", bus1.fifo_level_array_o, 8'h82);
    check("t4_wr",  bus1.broad_fifo_wr_o,    1'b0);
    bus1.broad_fifo_status_full_i = 1'b0;
    #1;
    check_fwd1("t4_fwd_a", 32'h3000, 0, 0);
    tick();
    check_fwd1("t4_fwd_b", 32'h3001, 0, 2);
    tick();
    check_fwd1("t4_fwd_c", 32'h3300, 3, 1);
    tick();
    check_fwd1("t4_fwd_d", 32'h3301, 3, 3);
    tick();
    check("t4_drained", bus1.broad_fifo_wr_o, 1'b0);

    // ID wrap: 130 single-port requests from a fresh reset
    do_reset();
    for (int n = 0; n < 130; n++) begin
      req0(0, MBUS_CMD_WR_BROAD, AW'(n));
      tick();
      check("t5_id", bus0.broad_id_o, 64'(n % 128));
      req0(0, MBUS_CMD_NOP, '0);
      tick();
    end

    // Reset mid-operation with two entries buffered (IDs 2 and 3 before reset)
    bus0.broad_fifo_status_full_i = 1'b1;
    req0(0, MBUS_CMD_WR_BROAD, 32'h4000);
    req0(1, MBUS_CMD_RD_BROAD, 32'h4100);
    tick();
    check("t6_ack", bus0.mbus_ack_array_o,   4'b0011);
    check("t6_lvl", bus0.fifo_level_array_o, 8'h05);
    req0(0, MBUS_CMD_NOP, '0);
    req0(1, MBUS_CMD_NOP, '0);
    bus0.broad_fifo_status_full_i = 1'b0;
    #1;
    check("t6_pre_wr", bus0.broad_fifo_wr_o, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_rst_ack",  bus0.mbus_ack_array_o,   '0);
    check("t6_rst_lvl",  bus0.fifo_level_array_o, '0);
    check("t6_rst_full", bus0.fifo_full_array_o,  '0);
    check_fwd0("t6_rst", 1'b0, '0, '0, 0, 0);
    tick();
    rst = 1'b1;
    req0(2, MBUS_CMD_WR_BROAD, 32'h5000);
    tick();
    check("t6_post_ack", bus0.mbus_ack_array_o, 4'b0100);
    check_fwd0("t6_post", 1'b1, 32'h5000, BROAD_TYPE_WR, 2, 0);
    req0(2, MBUS_CMD_NOP, '0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
